// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the EX stage and the divide unit.
// The pipeline side drives through master; the divider uses slave.
interface div_unit_if #(
  parameter int N       = 32,
  parameter int FUNCT_W = 2
);
  logic               start;
  logic               kill;
  logic [FUNCT_W-1:0] funct;
  logic [N-1:0]       x;
  logic [N-1:0]       y;
  logic               busy;
  logic               done;
  logic [N-1:0]       z;
  logic               div_zero;

  modport master (
    output start, kill, funct, x, y,
    input  busy, done, z, div_zero
  );

  modport slave (
    input  start, kill, funct, x, y,
    output busy, done, z, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider producing
// one quotient bit per cycle, with RISC-V defined results for /0 and overflow.
module div_unit #(
  parameter int N       = 32,
  parameter int FUNCT_W = 2
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [FUNCT_W-1:0] funct_r;
  logic [N-1:0]       x_r;
  logic [N-1:0]       y_r;
  logic [N-1:0]       q;
  logic [N-1:0]       rem;
  logic [N-1:0]       dvs;
  logic [CNT_W-1:0]   cnt;
  logic [N-1:0]       z_r;
  logic               dz_r;

  logic               is_signed;
  logic               is_rem;
  logic               y_zero;
  logic               ovf;
  logic               special;
  logic [N-1:0]       abs_x;
  logic [N-1:0]       abs_y;
  logic [N:0]         shifted;
  logic [N:0]         diff;
  logic               ge;
  logic [N-1:0]       rem_nx;
  logic [N-1:0]       q_nx;
  logic               neg_q;
  logic               neg_r;
  logic [N-1:0]       fix_val;
  logic [N-1:0]       special_val;
  logic               accept;

  // funct[0]=1 selects unsigned, funct[1]=1 selects remainder
  assign is_signed = ~funct_r[0];
  assign is_rem    = funct_r[1];
  assign y_zero    = (y_r == '0);
  assign ovf       = is_signed && (x_r == {1'b1, {(N-1){1'b0}}}) && (y_r == '1);
  assign special   = y_zero || ovf;

  // Negating the most negative value leaves it unchanged, which reads as +2^(N-1) unsigned
  assign abs_x = (is_signed && x_r[N-1]) ? -x_r : x_r;
  assign abs_y = (is_signed && y_r[N-1]) ? -y_r : y_r;

  // The partial remainder can reach 2*dvs-1, so the trial subtract is N+1 bits wide;
  // its top bit is set exactly when the subtraction would go negative.
  assign shifted = {rem, q[N-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign ge      = ~diff[N];
  assign rem_nx  = ge ? diff[N-1:0] : shifted[N-1:0];
  assign q_nx    = {q[N-2:0], ge};

  assign neg_q   = is_signed && (x_r[N-1] ^ y_r[N-1]);
  assign neg_r   = is_signed && x_r[N-1];
  assign fix_val = is_rem ? (neg_r ? -rem : rem) : (neg_q ? -q : q);

  // Overflow only occurs with x at the most negative value, so x_r is the DIV result there
  assign special_val = y_zero ? (is_rem ? x_r : '1) : (is_rem ? '0 : x_r);

  assign accept = (state == IDLE) && bus.start && !bus.kill;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; kill aborts everything except the already-committed DONE cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (bus.kill) begin
          state_nx = IDLE;
        end else if (special) begin
          state_nx = DONE;
        end else begin
          state_nx = CALC;
        end
      end
      CALC: begin
        if (bus.kill) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        if (bus.kill) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath; the result register is written on entry to DONE so z is valid with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct_r <= '0;
      x_r     <= '0;
      y_r     <= '0;
      q       <= '0;
      rem     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      z_r     <= '0;
      dz_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            funct_r <= bus.funct;
            x_r     <= bus.x;
            y_r     <= bus.y;
          end
        end
        CHECK: begin
          if (!bus.kill) begin
            if (special) begin
              z_r  <= special_val;
              dz_r <= y_zero;
            end else begin
              rem <= '0;
              q   <= abs_x;
              dvs <= abs_y;
              cnt <= CNT_W'(N - 1);
            end
          end
        end
        CALC: begin
          if (!bus.kill) begin
            rem <= rem_nx;
            q   <= q_nx;
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (!bus.kill) begin
            z_r  <= fix_val;
            dz_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.z        = z_r;
  assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge
// monitor pops and checks z, div_zero and latency on every done pulse.
module tb_div_unit;

  localparam int N = 32;

  typedef struct {
    logic [N-1:0] z;
    logic         dz;
    int           acc;
    int           lat;
    string        name;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;
  exp_t  sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  div_unit_if #(.N(N), .FUNCT_W(2)) bus ();

  div_unit #(.N(N), .FUNCT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Caller sits just after a negedge; returns just after the negedge following the accept
  task automatic applyStimulus(input string name, input logic [1:0] f, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [N-1:0] ez, input logic edz,
                               input int lat, input bit track);
    int guard;
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_idle_wait: busy stuck got %b expected 0", name, bus.busy);
    end
    bus.funct = f;
    bus.x     = a;
    bus.y     = b;
    bus.start = 1'b1;
    if (track) sb.push_back('{ez, edz, cyc, lat, name});
    @(negedge clk);
    bus.start = 1'b0;
    bus.funct = 2'($urandom_range(0, 3));
    bus.x     = $urandom;
    bus.y     = $urandom;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, "_pending"}, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 expected 0 (z=%0h)", bus.z);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_z"}, 64'(bus.z), 64'(e.z));
        checkOutput({e.name, "_dz"}, 64'(bus.div_zero), 64'(e.dz));
        checkOutput({e.name, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.funct = 2'b00;
    bus.x     = '0;
    bus.y     = '0;
    #12;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_z", 64'(bus.z), 64'd0);
    checkOutput("rst_dz", 64'(bus.div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back directed vectors: 00 DIV, 01 DIVU, 10 REM, 11 REMU
    applyStimulus("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 35, 1'b1);
    applyStimulus("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 35, 1'b1);
    applyStimulus("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 35, 1'b1);
    applyStimulus("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 35, 1'b1);
    applyStimulus("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2, 1'b1);
    applyStimulus("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1'b1, 2, 1'b1);
    applyStimulus("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2, 1'b1);
    applyStimulus("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 2, 1'b1);
    applyStimulus("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 35, 1'b1);
    applyStimulus("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 35, 1'b1);
    applyStimulus("rem_m8_3", 2'b10, 32'hFFFF_FFF8, 32'd3, 32'hFFFF_FFFE, 1'b0, 35, 1'b1);
    applyStimulus("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 35, 1'b1);
    applyStimulus("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1'b0, 35, 1'b1);
    applyStimulus("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 35, 1'b1);
    applyStimulus("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 35, 1'b1);

    // A start pulse while busy must be ignored; the monitor flags any extra done
    repeat (5) @(negedge clk);
    checkOutput("busy_mid", 64'(bus.busy), 64'd1);
    bus.start = 1'b1;
    bus.funct = 2'b01;
    bus.x     = 32'd1;
    bus.y     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    drain("seq");

    // Kill during the DONE cycle still delivers the result
    applyStimulus("remu_12_0_kill", 2'b11, 32'd12, 32'd0, 32'd12, 1'b1, 2, 1'b1);
    @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    drain("killdone");

    applyStimulus("divu_100_7b", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 35, 1'b1);
    drain("pre_kill");

    // Kill at cycle 10 of an op: no done, idle at cycle 11, result registers untouched
    applyStimulus("killed", 2'b01, 32'd100, 32'd7, 32'd0, 1'b0, 0, 1'b0);
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    checkOutput("kill_busy", 64'(bus.busy), 64'd0);
    checkOutput("kill_z", 64'(bus.z), 64'd14);
    checkOutput("kill_dz", 64'(bus.div_zero), 64'd0);
    applyStimulus("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 35, 1'b1);
    drain("post_kill");

    // Asynchronous reset mid-CALC clears outputs without a clock edge
    applyStimulus("reset_op", 2'b01, 32'd100, 32'd7, 32'd0, 1'b0, 0, 1'b0);
    repeat (19) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 64'(bus.busy), 64'd0);
    checkOutput("arst_done", 64'(bus.done), 64'd0);
    checkOutput("arst_z", 64'(bus.z), 64'd0);
    checkOutput("arst_dz", 64'(bus.div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("div_after_rst", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 35, 1'b1);
    drain("final");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
